// File: rtl/periph_bus_if.sv
// CPU-side request/response and peripheral strobe signals of the peripheral bus.
// The shared tristate data bus is not carried here. It is a direct inout port
// of the master, so that every driver of it is visible at one level.
interface periph_bus_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int PERIPH_ADDR_WIDTH = 2,
  parameter int DEV_SEL_WIDTH     = 2,
  parameter int CPU_ADDR_WIDTH    = 8
);
  logic                          cpu_req;
  logic                          cpu_we;
  logic [CPU_ADDR_WIDTH-1:0]     cpu_addr;
  logic [DATA_WIDTH-1:0]         cpu_wdata;
  logic [DATA_WIDTH-1:0]         cpu_rdata;
  logic                          cpu_ack;
  logic                          cpu_err;
  logic [PERIPH_ADDR_WIDTH-1:0]  p_addr;
  logic [2**DEV_SEL_WIDTH-1:0]   p_read;
  logic [2**DEV_SEL_WIDTH-1:0]   p_write;
  logic [2**DEV_SEL_WIDTH-1:0]   p_ready;
  logic [1:0]                    dbg_state;

  // Handshake: cpu_req is sampled only while the master is idle. Completion is
  // a single-cycle cpu_ack, with cpu_err qualifying it. A strobe bit stays high
  // until the selected device raises its p_ready bit or the timeout expires.
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, p_ready,
    output cpu_rdata, cpu_ack, cpu_err, p_addr, p_read, p_write, dbg_state
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, p_ready,
    input  cpu_rdata, cpu_ack, cpu_err, p_addr, p_read, p_write, dbg_state
  );
endinterface

// File: rtl/periph_bus_master.sv
// Peripheral bus master. It captures one CPU load/store and decodes the word
// address into {base, device, register}. It then runs one strobe cycle on the
// shared tristate data bus and waits for the selected device's ready signal.
// If ready does not arrive, a timeout ends the access. Completion is reported
// to the CPU as a one-cycle ack, with an optional error flag.
module periph_bus_master #(
  parameter int DATA_WIDTH        = 32,
  parameter int PERIPH_ADDR_WIDTH = 2,
  parameter int DEV_SEL_WIDTH     = 2,
  parameter int CPU_ADDR_WIDTH    = 8,
  parameter logic [CPU_ADDR_WIDTH-PERIPH_ADDR_WIDTH-DEV_SEL_WIDTH-1:0] BASE = 4'hF,
  parameter int TIMEOUT           = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  periph_bus_if.master          bus,
  inout  wire [DATA_WIDTH-1:0]  p_data
);

  localparam int DEV_COUNT = 2**DEV_SEL_WIDTH;
  localparam int DEV_LSB   = PERIPH_ADDR_WIDTH;
  localparam int BASE_LSB  = PERIPH_ADDR_WIDTH + DEV_SEL_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Last counter value before the access gives up. The counter is 8 bits wide
  // because TIMEOUT is at most 255.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]                   state;
  logic                         lat_we;
  logic [DEV_SEL_WIDTH-1:0]     lat_dev;
  logic [PERIPH_ADDR_WIDTH-1:0] lat_reg;
  logic [DATA_WIDTH-1:0]        lat_wdata;
  logic [7:0]                   cnt;
  logic                         err_q;
  logic [DATA_WIDTH-1:0]        rdata_q;

  logic                         base_hit;
  logic                         sel_ready;
  logic                         bus_drive;
  logic [DEV_COUNT-1:0]         rd_strobe;
  logic [DEV_COUNT-1:0]         wr_strobe;

  assign base_hit  = (bus.cpu_addr[CPU_ADDR_WIDTH-1:BASE_LSB] == BASE);
  // Only the latched device can complete the access. Ready from any other
  // device is ignored.
  assign sel_ready = bus.p_ready[lat_dev];

  // Request capture, access sequencing, timeout counting and response latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_we    <= 1'b0;
      lat_dev   <= '0;
      lat_reg   <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.cpu_req) begin
            lat_we    <= bus.cpu_we;
            lat_dev   <= bus.cpu_addr[BASE_LSB-1:DEV_LSB];
            lat_reg   <= bus.cpu_addr[PERIPH_ADDR_WIDTH-1:0];
            lat_wdata <= bus.cpu_wdata;
            if (base_hit) begin
              err_q <= 1'b0;
              state <= ST_ACCESS;
            end else begin
              // A decode miss skips the bus entirely and reports an error.
              err_q <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            if (!lat_we) begin
              rdata_q <= p_data;
            end
            err_q <= 1'b0;
            cnt   <= '0;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            // A read that times out returns zero. A write leaves the read data unchanged.
            if (!lat_we) begin
              rdata_q <= '0;
            end
            err_q <= 1'b1;
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // One-hot strobe toward the latched device, asserted only while ACCESS is held.
  always_comb begin
    rd_strobe = '0;
    wr_strobe = '0;
    if (state == ST_ACCESS) begin
      if (lat_we) begin
        wr_strobe[lat_dev] = 1'b1;
      end else begin
        rd_strobe[lat_dev] = 1'b1;
      end
    end
  end

  assign bus_drive     = (state == ST_ACCESS) && lat_we;
  assign p_data        = bus_drive ? lat_wdata : {DATA_WIDTH{1'bz}};

  assign bus.p_read    = rd_strobe;
  assign bus.p_write   = wr_strobe;
  assign bus.p_addr    = (state == ST_ACCESS) ? lat_reg : '0;
  assign bus.cpu_ack   = (state == ST_DONE);
  assign bus.cpu_err   = (state == ST_DONE) && err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master. It provides four bus devices with register
// files: devices 0, 1 and 3 are ready immediately and device 2 never answers.
// A transaction-level model predicts strobes and acks from the request
// timeline, and directed tests pin the expected latencies and data.
module tb_periph_bus_master;

  localparam int         TIMEOUT = 15;
  localparam logic [3:0] BASE    = 4'hF;
  localparam logic [3:0] DEV_RDY = 4'b1011;

  logic clk;
  logic rst;
  wire  [31:0] p_data;

  periph_bus_if #(.DATA_WIDTH(32), .PERIPH_ADDR_WIDTH(2), .DEV_SEL_WIDTH(2),
                  .CPU_ADDR_WIDTH(8)) bus ();

  periph_bus_master #(.DATA_WIDTH(32), .PERIPH_ADDR_WIDTH(2), .DEV_SEL_WIDTH(2),
                      .CPU_ADDR_WIDTH(8), .BASE(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .p_data (p_data)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_val(input int d, input int r);
    if (d == 1 && r == 3) return 32'h1234_5678;
    return 32'hD000_0000 | 32'(d << 4) | 32'(r);
  endfunction

  // ---------------- bus devices ----------------
  logic [31:0] dmem [4][4];
  logic        dev_drv_en;
  logic [31:0] dev_drv_val;
  logic [3:0]  dev_ready;

  // Each device answers its own strobe. A read drives the register onto the bus.
  always_comb begin
    dev_drv_en  = 1'b0;
    dev_drv_val = '0;
    dev_ready   = '0;
    for (int d = 0; d < 4; d++) begin
      if (bus.p_read[d] || bus.p_write[d]) dev_ready[d] = DEV_RDY[d];
      if (bus.p_read[d]) begin
        dev_drv_en  = 1'b1;
        dev_drv_val = dmem[d][bus.p_addr];
      end
    end
  end
  assign bus.p_ready = dev_ready;
  assign p_data = dev_drv_en ? dev_drv_val : 32'bz;

  // Device register files capture a write when ready is given.
  always @(posedge clk) begin
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 4; r++)
        if (rst) dmem[d][r] <= init_val(d, r);
        else if (bus.p_write[d] && dev_ready[d] && bus.p_addr == 2'(r)) dmem[d][r] <= p_data;
  end

  // ---------------- transaction-level model ----------------
  // Each accepted request has a timeline: the strobe lasts m_len cycles from the
  // accept edge and the ack lies in the cycle ending at edge m_a.
  int          cyc = 0;
  logic        started = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_acc = 1'b0;
  int          m_n, m_a, m_len;
  logic        m_hit, m_err, m_to, m_we;
  int          m_dev;
  logic [1:0]  m_reg;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic [31:0] exp_mem [4][4];
  int          e, len, dev;
  logic        hit;

  always @(posedge clk) begin
    e = cyc;
    cyc <= cyc + 1;
    m_acc <= 1'b0;
    if (rst) begin
      started <= 1'b1;
      m_valid <= 1'b0;
      m_rdata <= '0;
      for (int d = 0; d < 4; d++)
        for (int r = 0; r < 4; r++) exp_mem[d][r] <= init_val(d, r);
    end else begin
      if (m_valid && m_hit && e == m_a - 1) begin
        if (m_to) begin
          if (!m_we) m_rdata <= '0;
        end else if (m_we) exp_mem[m_dev][m_reg] <= m_wdata;
        else m_rdata <= exp_mem[m_dev][m_reg];
      end
      if (bus.cpu_req && (!m_valid || e >= m_a + 1)) begin
        hit = (bus.cpu_addr[7:4] == BASE);
        dev = int'(bus.cpu_addr[3:2]);
        len = !hit ? 0 : (DEV_RDY[dev] ? 1 : TIMEOUT);
        m_valid <= 1'b1;
        m_acc   <= 1'b1;
        m_n     <= e;
        m_a     <= e + 1 + len;
        m_len   <= len;
        m_hit   <= hit;
        m_to    <= hit && !DEV_RDY[dev];
        m_err   <= !hit || !DEV_RDY[dev];
        m_we    <= bus.cpu_we;
        m_dev   <= dev;
        m_reg   <= bus.cpu_addr[1:0];
        m_wdata <= bus.cpu_wdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int          k;
  logic        strobe, exp_ack;
  logic [3:0]  oh, exp_pr, exp_pw;
  logic [1:0]  exp_pa;
  int          strobe_cnt = 0;
  int          ack_cnt = 0;
  logic [3:0]  last_pr, last_pw;
  logic [1:0]  last_pa;
  logic [31:0] last_pd;
  int          ack_q[$];
  logic [31:0] rd_q[$];

  always @(negedge clk) begin
    if (started) begin
      k       = cyc - 1;
      strobe  = m_valid && m_hit && (k >= m_n) && (k < m_n + m_len);
      oh      = 4'(1 << m_dev);
      exp_pr  = (strobe && !m_we) ? oh : 4'b0;
      exp_pw  = (strobe && m_we) ? oh : 4'b0;
      exp_pa  = strobe ? m_reg : 2'b0;
      exp_ack = m_valid && (k == m_a - 1);
      check("cpu_ack", 32'(bus.cpu_ack), 32'(exp_ack));
      check("cpu_err", 32'(bus.cpu_err), 32'(exp_ack && m_err));
      check("cpu_rdata", bus.cpu_rdata, m_rdata);
      check("p_read", 32'(bus.p_read), 32'(exp_pr));
      check("p_write", 32'(bus.p_write), 32'(exp_pw));
      check("p_addr", 32'(bus.p_addr), 32'(exp_pa));
      if (exp_pw != 4'b0) check("p_data", p_data, m_wdata);
      if (bus.cpu_ack) begin
        ack_cnt++;
        ack_q.push_back(cyc);
        rd_q.push_back(bus.cpu_rdata);
      end
      if ((bus.p_read | bus.p_write) != 4'b0) begin
        strobe_cnt++;
        last_pr = bus.p_read;
        last_pw = bus.p_write;
        last_pa = bus.p_addr;
        last_pd = p_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_e;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present a request and hold it until the model sees it accepted. The task
  // returns in the cycle after the accept edge, with cpu_req still high.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wd);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        acc_e = m_n;
        tick();
        return;
      end
    end
    check("accept_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_ack(output int ack_edge, output logic err, output logic [31:0] rd);
    ack_edge = -1;
    err = 1'b0;
    rd = '0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cpu_ack) begin
        ack_edge = cyc;
        err = bus.cpu_err;
        rd = bus.cpu_rdata;
        return;
      end
      tick();
    end
    check("ack_bound", 32'd0, 32'd1);
  endtask

  // ---------------- scoreboard / directed tests ----------------
  logic [31:0] exp_q[$];
  logic [31:0] b2b [4];
  int          ae, s0, a0;
  logic        er;
  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    b2b[0] = 32'h1111_0000;
    b2b[1] = 32'h2222_0001;
    b2b[2] = 32'h3333_0002;
    b2b[3] = 32'h4444_0003;
    repeat (3) @(posedge clk);
    tick();
    rst = 1'b0;
    check("rst_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_strobes", 32'({bus.p_read, bus.p_write}), 32'd0);

    // 1: write to device 3, register 3
    s0 = strobe_cnt;
    issue(1'b1, 8'hFF, 32'h8000_00A5);
    bus.cpu_req = 1'b0;
    wait_ack(ae, er, rd);
    check("t1_latency", 32'(ae - acc_e), 32'd2);
    check("t1_err", 32'(er), 32'd0);
    check("t1_strobe_cycles", 32'(strobe_cnt - s0), 32'd1);
    check("t1_p_write", 32'(last_pw), 32'h8);
    check("t1_p_addr", 32'(last_pa), 32'd3);
    check("t1_p_data", last_pd, 32'h8000_00A5);
    tick();

    // 2: read from device 1, register 3
    issue(1'b0, 8'hF7, 32'h0);
    bus.cpu_req = 1'b0;
    wait_ack(ae, er, rd);
    check("t2_latency", 32'(ae - acc_e), 32'd2);
    check("t2_err", 32'(er), 32'd0);
    check("t2_rdata", rd, 32'h1234_5678);
    check("t2_p_read", 32'(last_pr), 32'h2);
    tick();

    // 3: timeout on device 2
    s0 = strobe_cnt;
    issue(1'b0, 8'hF8, 32'h0);
    bus.cpu_req = 1'b0;
    wait_ack(ae, er, rd);
    check("t3_latency", 32'(ae - acc_e), 32'd16);
    check("t3_err", 32'(er), 32'd1);
    check("t3_rdata", rd, 32'd0);
    check("t3_strobe_cycles", 32'(strobe_cnt - s0), 32'd15);
    check("t3_p_read", 32'(last_pr), 32'h4);
    tick();
    check("t3_after_strobes", 32'({bus.p_read, bus.p_write}), 32'd0);

    // 4: decode miss
    s0 = strobe_cnt;
    issue(1'b0, 8'h3C, 32'h0);
    bus.cpu_req = 1'b0;
    wait_ack(ae, er, rd);
    check("t4_latency", 32'(ae - acc_e), 32'd1);
    check("t4_err", 32'(er), 32'd1);
    tick();
    check("t4_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // 5: reset in the middle of an access
    issue(1'b0, 8'hF9, 32'h0);
    bus.cpu_req = 1'b0;
    a0 = ack_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_strobes", 32'({bus.p_read, bus.p_write}), 32'd0);
    repeat (20) tick();
    check("t5_no_ack", 32'(ack_cnt - a0), 32'd0);
    issue(1'b1, 8'hF1, 32'hCAFE_0001);
    bus.cpu_req = 1'b0;
    wait_ack(ae, er, rd);
    check("t5_next_latency", 32'(ae - acc_e), 32'd2);
    check("t5_next_err", 32'(er), 32'd0);
    tick();

    // 6: back-to-back writes and then reads to device 0, with cpu_req held high
    ack_q.delete();
    rd_q.delete();
    for (int r = 0; r < 4; r++) begin
      issue(1'b1, 8'hF0 | 8'(r), b2b[r]);
      exp_q.push_back(b2b[r]);
    end
    for (int r = 0; r < 4; r++) issue(1'b0, 8'hF0 | 8'(r), 32'h0);
    bus.cpu_req = 1'b0;
    repeat (6) tick();
    check("t6_ack_count", 32'(ack_q.size()), 32'd8);
    if (ack_q.size() == 8) begin
      for (int i = 1; i < 8; i++) check("t6_ack_spacing", 32'(ack_q[i] - ack_q[i-1]), 32'd3);
      for (int i = 4; i < 8; i++) check("t6_readback", rd_q[i], exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
